// File: rtl/mux8_arbiter16.sv
// mux8_arbiter16: eight-source collecting mux with round-robin arbitration into one registered output word.
// Define MUX8_ARB_FIXED_PRIO_EN for fixed lowest-index priority; this removes the rotating pointer.
module mux8_arbiter16 #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSRC-1:0]       req,
    input  logic [WIDTH*NSRC-1:0] in_data,
    output logic [NSRC-1:0]       gnt,
    output logic [WIDTH-1:0]      out_data,
    output logic [2:0]            out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [2:0]       scan_base;
    logic [2:0]       scan_idx;
    logic [2:0]       winner;
    logic             found;
    logic             load;

`ifdef MUX8_ARB_FIXED_PRIO_EN
    assign scan_base = 3'd0;
`else
    logic [2:0] ptr_q, ptr_d;

    assign scan_base = ptr_q;
    assign ptr_d     = winner + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 3'd0;
        end else if (load) begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // First requester at or after scan_base, wrapping modulo 8.
    always_comb begin
        winner   = 3'd0;
        found    = 1'b0;
        scan_idx = 3'd0;
        for (int k = 0; k < NSRC; k++) begin
            scan_idx = scan_base + 3'(k);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    assign load = (|req) && (!valid_q || out_ready) && !rst;
    assign gnt  = load ? ({{(NSRC-1){1'b0}}, 1'b1} << winner) : '0;

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = in_data[winner*WIDTH +: WIDTH];
            sel_d   = winner;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux8_arbiter16.sv
// tb_mux8_arbiter16: scoreboard bench for mux8_arbiter16; expected words queued at grant, checked at capture.
// Honours MUX8_ARB_FIXED_PRIO_EN the same way as the design.
module tb_mux8_arbiter16;

`ifdef MUX8_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   req = 8'h00;
    logic [127:0] in_data = '0;
    logic [7:0]   gnt;
    logic [15:0]  out_data;
    logic [2:0]   out_sel;
    logic         out_valid;
    logic         out_ready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]  m_ptr   = 3'd0;
    logic        m_valid = 1'b0;
    logic [18:0] sb_q[$];

    always #5 clk = ~clk;

    mux8_arbiter16 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Rotate requests so the pointer position lands at bit 0, then take the lowest set bit.
    function automatic logic [2:0] m_winner(input logic [7:0] r, input logic [2:0] p);
        logic [15:0] dbl;
        logic [2:0]  w;
        dbl = {r, r} >> p;
        w   = 3'd0;
        for (int j = 7; j >= 0; j--) begin
            if (dbl[j]) w = p + 3'(j);
        end
        return w;
    endfunction

    task automatic tick();
        logic [2:0]  w;
        logic        ld;
        logic [7:0]  eg;
        logic [18:0] item;
        @(negedge clk);
        ld = (req != 8'h00) && (!m_valid || out_ready) && !rst;
        w  = m_winner(req, FIXED ? 3'd0 : m_ptr);
        eg = ld ? (8'b1 << w) : 8'h00;
        chk("gnt", 32'(gnt), 32'(eg));
        if (ld) sb_q.push_back({w, in_data[16*w +: 16]});
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 3'd0;
        end else if (ld) begin
            m_valid = 1'b1;
            if (!FIXED) m_ptr = w + 3'd1;
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'(1), 32'(0));
            end else begin
                item = sb_q.pop_front();
                chk("sb_word", 32'({out_sel, out_data}), 32'(item));
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
    endtask

    task automatic set_rr_words();
        for (int i = 0; i < 8; i++) in_data[16*i +: 16] = 16'h1000 + 16'(i);
    endtask

    initial begin
        // Reset with every source requesting
        rst = 1'b1; req = 8'hFF; out_ready = 1'b1;
        set_rr_words();
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_data", 32'(out_data), 32'(16'h0000));
        chk("rst_sel", 32'(out_sel), 32'(0));
        rst = 1'b0;
        tick();
        chk("first_after_rst", 32'(out_sel), 32'(0));

        // Single source
        req = 8'b0010_0000;
        in_data[16*5 +: 16] = 16'hFEEF;
        tick();
        chk("single_data", 32'(out_data), 32'(16'hFEEF));
        chk("single_sel", 32'(out_sel), 32'(5));

        // Round-robin from a cleared pointer, then reset mid-stream
        rst = 1'b1; req = 8'h00;
        tick();
        rst = 1'b0; req = 8'hFF;
        set_rr_words();
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("rr_sel", 32'(out_sel), FIXED ? 32'(0) : 32'(k % 8));
            chk("rr_data", 32'(out_data), FIXED ? 32'(16'h1000) : 32'(16'h1000 + (k % 8)));
        end
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(out_valid), 32'(0));
        rst = 1'b0; out_ready = 1'b1;
        tick();
        chk("midrst_next_sel", 32'(out_sel), 32'(0));

        // Backpressure
        req = 8'b0001_0000;
        in_data[16*4 +: 16] = 16'h10AF;
        tick();
        chk("bp_load_sel", 32'(out_sel), 32'(4));
        req = 8'b1000_0000; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_data", 32'(out_data), 32'(16'h10AF));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_sel", 32'(out_sel), 32'(7));
        chk("bp_release_valid", 32'(out_valid), 32'(1));

        // Wrap and skip
        req = 8'b0100_0000;
        tick();
        req = 8'b0000_0101;
        tick();
        chk("wrap_first", 32'(out_sel), 32'(0));
        req = 8'b0000_0100;
        tick();
        chk("wrap_second", 32'(out_sel), 32'(2));
        req = 8'h00;
        tick();
        chk("drain_valid", 32'(out_valid), 32'(0));

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            req       = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) in_data[16*i +: 16] = 16'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
